// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare
//
// Fetch-stage gshare direction predictor. The table holds 2-bit saturating
// counters and is indexed by the low PC bits XOR the global history register
// (GHR). The prediction and its index are combinational from pc and the
// registered state. Training happens when EX resolves a conditional branch.
// The GHR is non-speculative: it shifts only on resolution.
//
// Ports:
//   clk               : sole clock, rising edge
//   reset             : asynchronous, active-high
//   pc                : fetch PC (word-addressed)
//   branch_prediction : predicted taken (MSB of the selected counter)
//   pred_index        : table index used for this prediction, carried to EX
//   update_valid      : EX resolved a conditional branch this cycle
//   update_index      : pred_index that travelled with the resolved branch
//   update_taken      : actual branch outcome
//   update_mispredict : prediction used was wrong (qualified by update_valid)
//   branch_count      : resolved conditional branches (saturating)
//   mispredict_count  : mispredicted conditional branches (saturating)

module branch_predictor_gshare #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   pc,
  output logic                  branch_prediction,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken,
  input  logic                  update_mispredict,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic [CNT_WIDTH-1:0]  mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [1:0]            ctr_table_r [ENTRIES];
  logic [INDEX_BITS-1:0] ghr_r;
  logic [CNT_WIDTH-1:0]  branch_count_r;
  logic [CNT_WIDTH-1:0]  mispredict_count_r;
  logic [INDEX_BITS-1:0] pred_index_s;

  // The upper PC bits do not take part in the hash.
  logic unused_pc_bits_s;
  assign unused_pc_bits_s = ^pc[PC_WIDTH-1:INDEX_BITS];

  // One saturating step of a 2-bit direction counter.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return nxt;
  endfunction

  // gshare hash: low PC bits XOR committed history.
  assign pred_index_s      = pc[INDEX_BITS-1:0] ^ ghr_r;
  assign pred_index        = pred_index_s;
  // The read sees the pre-update table; a same-cycle write is not bypassed.
  assign branch_prediction = ctr_table_r[pred_index_s][1];

  assign branch_count     = branch_count_r;
  assign mispredict_count = mispredict_count_r;

  // Counter table: reset to weak-NT, train the entry named by EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_table_r[i] <= 2'b01;
      end
    end else if (update_valid) begin
      // The write uses the index EX carried, never a recomputed hash.
      ctr_table_r[update_index] <= sat_step(ctr_table_r[update_index], update_taken);
    end else begin
      ctr_table_r <= ctr_table_r;
    end
  end

  // Global history: shift in resolved outcomes only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_r <= {INDEX_BITS{1'b0}};
    end else if (update_valid) begin
      ghr_r <= {ghr_r[INDEX_BITS-2:0], update_taken};
    end else begin
      ghr_r <= ghr_r;
    end
  end

  // Performance counters: saturate at all-ones rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count_r     <= {CNT_WIDTH{1'b0}};
      mispredict_count_r <= {CNT_WIDTH{1'b0}};
    end else if (update_valid) begin
      if (branch_count_r != CNT_MAX) begin
        branch_count_r <= branch_count_r + CNT_ONE;
      end else begin
        branch_count_r <= branch_count_r;
      end
      if (update_mispredict && (mispredict_count_r != CNT_MAX)) begin
        mispredict_count_r <= mispredict_count_r + CNT_ONE;
      end else begin
        mispredict_count_r <= mispredict_count_r;
      end
    end else begin
      branch_count_r     <= branch_count_r;
      mispredict_count_r <= mispredict_count_r;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench for branch_predictor_gshare.
// Two instances share all inputs: one with 32-bit counters, one with 4-bit
// counters to exercise saturation. A behavioural model (integer counters,
// integer history) predicts every output.

module tb_branch_predictor_gshare;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        update_valid;
  logic [5:0]  update_index;
  logic        update_taken;
  logic        update_mispredict;

  logic        branch_prediction;
  logic [5:0]  pred_index;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  logic        branch_prediction4;
  logic [5:0]  pred_index4;
  logic [3:0]  branch_count4;
  logic [3:0]  mispredict_count4;

  int compared;
  int mismatched;

  // Reference model state
  int     m_table [64];
  int     m_ghr;
  longint m_bc, m_mc;
  int     m_bc4, m_mc4;

  branch_predictor_gshare #(.PC_WIDTH(32), .INDEX_BITS(6), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .branch_prediction(branch_prediction), .pred_index(pred_index),
    .update_valid(update_valid), .update_index(update_index),
    .update_taken(update_taken), .update_mispredict(update_mispredict),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predictor_gshare #(.PC_WIDTH(32), .INDEX_BITS(6), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .pc(pc),
    .branch_prediction(branch_prediction4), .pred_index(pred_index4),
    .update_valid(update_valid), .update_index(update_index),
    .update_taken(update_taken), .update_mispredict(update_mispredict),
    .branch_count(branch_count4), .mispredict_count(mispredict_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_table[i] = 1;
    m_ghr = 0; m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
  endtask

  task automatic model_update(input int idx, input bit t, input bit m);
    if (t) m_table[idx] = (m_table[idx] < 3) ? m_table[idx] + 1 : 3;
    else   m_table[idx] = (m_table[idx] > 0) ? m_table[idx] - 1 : 0;
    m_ghr = ((m_ghr * 2) + (t ? 1 : 0)) % 64;
    if (m_bc < 64'd4294967295) m_bc = m_bc + 1;
    if (m && m_mc < 64'd4294967295) m_mc = m_mc + 1;
    if (m_bc4 < 15) m_bc4 = m_bc4 + 1;
    if (m && m_mc4 < 15) m_mc4 = m_mc4 + 1;
  endtask

  task automatic check_counts();
    check("branch_count", branch_count, m_bc);
    check("mispredict_count", mispredict_count, m_mc);
    check("branch_count4", branch_count4, m_bc4);
    check("mispredict_count4", mispredict_count4, m_mc4);
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, check counters.
  task automatic do_cycle(input logic [31:0] p, input bit v, input int idx, input bit t, input bit m);
    int exp_idx;
    pc = p; update_valid = v; update_index = idx[5:0];
    update_taken = t; update_mispredict = m;
    #1;
    exp_idx = (int'(p % 64)) ^ m_ghr;
    check("pred_index", pred_index, exp_idx);
    check("branch_prediction", branch_prediction, (m_table[exp_idx] >= 2) ? 1 : 0);
    check("pred_index4", pred_index4, exp_idx);
    check("branch_prediction4", branch_prediction4, (m_table[exp_idx] >= 2) ? 1 : 0);
    @(posedge clk);
    if (v) model_update(idx, t, m);
    #1;
    check_counts();
    @(negedge clk);
  endtask

  initial begin
    int idx;
    compared = 0;
    mismatched = 0;
    model_reset();

    // Reset state
    reset = 1'b1; pc = 32'h25; update_valid = 1'b0; update_index = 6'd0;
    update_taken = 1'b0; update_mispredict = 1'b0;
    #3;
    check("reset_pred", branch_prediction, 1'b0);
    check("reset_idx", pred_index, 6'h25);
    check("reset_bc", branch_count, 32'd0);
    check("reset_mc", mispredict_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Saturate up: entry 5, watched through pc = 5 ^ ghr
    for (int k = 0; k < 3; k++) do_cycle(32'(5 ^ m_ghr), 1'b1, 5, 1'b1, 1'b0);
    // Index hash with ghr = 0x07
    do_cycle(32'h02, 1'b0, 0, 1'b0, 1'b0);
    check("hash_idx", pred_index, 6'h05);
    check("hash_pred", branch_prediction, 1'b1);

    // Saturate down; first step is the same-cycle read/update of index 5
    do_cycle(32'h02, 1'b1, 5, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) do_cycle(32'(5 ^ m_ghr), 1'b1, 5, 1'b0, 1'b1);
    do_cycle(32'(5 ^ m_ghr), 1'b0, 0, 1'b0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      do_cycle($urandom, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset between edges while an update is pending
    pc = 32'h3a; update_valid = 1'b1; update_index = 6'd9;
    update_taken = 1'b1; update_mispredict = 1'b1;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("midrst_idx", pred_index, 6'h3a);
    check("midrst_pred", branch_prediction, 1'b0);
    check_counts();
    @(posedge clk);
    #1;
    check("midrst_edge_bc", branch_count, 32'd0);
    check_counts();
    @(negedge clk);
    reset = 1'b0;

    // Every entry back at weak-NT (ghr = 0 so pc i selects entry i)
    for (int i = 0; i < 64; i++) do_cycle(32'(i), 1'b0, 0, 1'b0, 1'b0);

    // Counter saturation: 17 mispredicted updates
    for (int k = 0; k < 17; k++) begin
      idx = int'($urandom_range(0, 63));
      do_cycle(32'(idx ^ m_ghr), 1'b1, idx, 1'($urandom_range(0, 1)), 1'b1);
    end
    check("sat_bc4", branch_count4, 4'd15);
    check("sat_mc4", mispredict_count4, 4'd15);
    check("sat_bc", branch_count, 32'd17);
    check("sat_mc", mispredict_count, 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
